// File: rtl/quad_sqrt_if.sv
// Handshake bundle for quad_sqrt: operand in (c_data, 5.24) and magnitude out (r_data, 3.12).
interface quad_sqrt_if;
    logic        in_valid;
    logic        in_ready;
    logic [28:0] c_data;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] r_data;

    modport master (
        output in_valid,
        output c_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  r_data
    );

    modport slave (
        input  in_valid,
        input  c_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output r_data
    );
endinterface

// File: rtl/quad_sqrt.sv
// Radix-2 digit-recurrence square root, one root bit per clock: r = sqrt(c), 5.24 -> 3.12.
// Define SQRT_ROUND_EN for a 16-bit root with a guard bit and round-half-up to 15 bits.
module quad_sqrt #(
    parameter int unsigned FWL_R = 12
) (
    input  logic        clk,
    input  logic        rstn,
    quad_sqrt_if.slave  sif,
    output logic        busy
);

`ifdef SQRT_ROUND_EN
    localparam int unsigned N = 16;
`else
    localparam int unsigned N = 15;
`endif
    localparam int unsigned OPW = 2 * N;
    localparam int unsigned RW  = N + 2;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q, state_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [N-1:0]     root_q, root_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [14:0]      r_data_q, r_data_d;

    logic [OPW-1:0]   operand;
    logic [RW-1:0]    rem_sh;
    logic [RW:0]      trial;
    logic [14:0]      root_fin;
    logic [14:0]      root_trunc;

`ifdef SQRT_ROUND_EN
    // Two extra zero bits feed the guard iteration.
    assign operand = {1'b0, sif.c_data, 2'b00};

    logic [N:0] root_rnd;
    assign root_rnd = {1'b0, root_q} + 1'b1;
    assign root_fin = root_rnd[N] ? 15'h7FFF : root_rnd[N-1:1];
`else
    assign operand  = {1'b0, sif.c_data};
    assign root_fin = root_q;
`endif

    generate
        if (FWL_R >= 12) begin : g_full
            assign root_trunc = root_fin;
        end else begin : g_trunc
            assign root_trunc = {root_fin[14:12-FWL_R], {(12-FWL_R){1'b0}}};
        end
    endgenerate

    assign rem_sh = (rem_q << 2) | RW'(op_q[OPW-1 -: 2]);
    assign trial  = {1'b0, rem_sh} - {1'b0, root_q, 2'b01};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            op_q        <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            r_data_q    <= '0;
        end else begin
            op_q        <= op_d;
            rem_q       <= rem_d;
            root_q      <= root_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            r_data_q    <= r_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rem_d       = rem_q;
        root_d      = root_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        r_data_d    = r_data_q;
        unique case (state_q)
            StIdle: begin
                if (sif.in_valid) begin
                    op_d    = operand;
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = 4'(N - 1);
                    state_d = StCalc;
                end
            end
            StCalc: begin
                op_d   = op_q << 2;
                rem_d  = trial[RW] ? rem_sh : trial[RW-1:0];
                root_d = {root_q[N-2:0], ~trial[RW]};
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                // First DONE cycle registers the result; out_ready is ignored until then.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    r_data_d    = root_trunc;
                end else if (sif.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign sif.in_ready  = (state_q == StIdle);
    assign sif.out_valid = out_valid_q;
    assign sif.r_data    = r_data_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_quad_sqrt.sv
// Scoreboard bench for quad_sqrt: two instances (FWL_R=12 and FWL_R=8) share one stimulus stream.
`timescale 1ns/1ps
module tb_quad_sqrt;

`ifdef SQRT_ROUND_EN
    localparam int N = 16;
`else
    localparam int N = 15;
`endif
    localparam int FWL_B = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic [28:0] c_data;
    logic        out_ready = 1'b1;
    logic        busy_a, busy_b;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          accept_cyc = 0;
    bit          lat_armed = 1'b0;
    bit          rand_rdy = 1'b0;
    bit          force_rdy = 1'b1;
    logic [14:0] qa[$];
    logic [14:0] qb[$];
    logic        prev_ov = 1'b0;
    logic        hold = 1'b0;
    logic [14:0] hold_val = '0;

    quad_sqrt_if ifa ();
    quad_sqrt_if ifb ();

    assign ifa.in_valid  = in_valid;
    assign ifa.c_data    = c_data;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.c_data    = c_data;
    assign ifb.out_ready = out_ready;

    quad_sqrt #(.FWL_R(12)) dut_a (
        .clk  (clk),
        .rstn (rstn),
        .sif  (ifa.slave),
        .busy (busy_a)
    );

    quad_sqrt #(.FWL_R(FWL_B)) dut_b (
        .clk  (clk),
        .rstn (rstn),
        .sif  (ifb.slave),
        .busy (busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: exact integer sqrt of the scaled operand, then rounding and word-length cut.
    function automatic logic [14:0] model(input logic [28:0] c, input int fwl);
        longint v;
        longint r;
        v = longint'(c);
`ifdef SQRT_ROUND_EN
        v = v * 4;
`endif
        r = longint'($sqrt(real'(v)));
        while (r * r > v) r--;
        while ((r + 1) * (r + 1) <= v) r++;
`ifdef SQRT_ROUND_EN
        r = (r + 1) / 2;
        if (r > 32767) r = 32767;
`endif
        r = (r >> (12 - fwl)) << (12 - fwl);
        return r[14:0];
    endfunction

    task automatic send(input logic [28:0] c, input logic [14:0] ea, input logic [14:0] eb);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        c_data   = c;
        while (!ifa.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ifa.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready still %0b after %0d cycles, required 1",
                     ifa.in_ready, t);
            in_valid = 1'b0;
        end else begin
            qa.push_back(ea);
            qb.push_back(eb);
            @(posedge clk);
            #1;
            accept_cyc = cyc;
            lat_armed  = 1'b1;
            in_valid   = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (qa.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", qa.size(), 0);
    endtask

    // Monitor: pops expected results on every output handshake; also checks hold and latency.
    always @(negedge clk) begin
        logic [14:0] ea, eb;
        if (!rstn) begin
            prev_ov = 1'b0;
            hold    = 1'b0;
        end else begin
            if (ifa.out_valid || ifb.out_valid) check("out_valid_a_vs_b", ifb.out_valid, ifa.out_valid);
            if (ifa.out_valid && !prev_ov && lat_armed) begin
                check("latency", cyc - accept_cyc, N + 1);
                lat_armed = 1'b0;
            end
            if (hold) begin
                check("hold_valid", ifa.out_valid, 1);
                check("hold_data", ifa.r_data, hold_val);
            end
            hold = 1'b0;
            if (ifa.out_valid) begin
                if (out_ready) begin
                    if (qa.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: r_data=%h presented, none expected",
                                 ifa.r_data);
                    end else begin
                        ea = qa.pop_front();
                        eb = qb.pop_front();
                        check("r_data_fwl12", ifa.r_data, ea);
                        check("r_data_fwl8", ifb.r_data, eb);
                    end
                end else begin
                    hold     = 1'b1;
                    hold_val = ifa.r_data;
                end
            end
            prev_ov = ifa.out_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: no finish by t=%0t, required completion", $time);
        $fatal(1);
    end

    initial begin
        logic [28:0] dc[5];
        logic [14:0] da[5];
        logic [14:0] db[5];
        logic [14:0] ea, eb;
        logic [28:0] c;
        int          t;

        dc = '{29'h1000000, 29'h0, 29'h4000000, 29'h2000000, 29'h1FFFFFFF};
        da = '{15'h1000, 15'h0000, 15'h2000, 15'h16A0, 15'h5A82};
        db = '{15'h1000, 15'h0000, 15'h2000, 15'h16A0, 15'h5A80};

        rstn     = 1'b0;
        in_valid = 1'b0;
        c_data   = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("reset_in_ready", ifa.in_ready, 1);
        check("reset_out_valid", ifa.out_valid, 0);
        check("reset_r_data", ifa.r_data, 0);
        check("reset_busy", busy_a, 0);

        // Directed corner values
        for (int i = 0; i < 5; i++) begin
`ifdef SQRT_ROUND_EN
            ea = model(dc[i], 12);
            eb = model(dc[i], FWL_B);
`else
            ea = da[i];
            eb = db[i];
`endif
            send(dc[i], ea, eb);
            @(negedge clk);
            check("busy_in_calc", busy_a, 1);
            check("in_ready_in_calc", ifa.in_ready, 0);
            drain();
        end

        // Backpressure with ignored in_valid pulses
        force_rdy = 1'b0;
        @(posedge clk);
        send(29'h2000000, model(29'h2000000, 12), model(29'h2000000, FWL_B));
        t = 0;
        while (!ifa.out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("bp_valid_seen", ifa.out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", ifa.in_ready, 0);
            in_valid = (i == 3 || i == 4);
            c_data   = 29'h0ABCDEF;
        end
        in_valid  = 1'b0;
        force_rdy = 1'b1;
        t = 0;
        while (ifa.out_valid && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("bp_release_in_ready", ifa.in_ready, 1);
        check("bp_release_busy", busy_a, 0);
        drain();

        // Reset in the middle of CALC discards the result
        send(29'h1000000, 15'h1000, 15'h1000);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rstn      = 1'b0;
        lat_armed = 1'b0;
        qa.delete();
        qb.delete();
        @(negedge clk);
        check("abort_out_valid", ifa.out_valid, 0);
        check("abort_r_data", ifa.r_data, 0);
        check("abort_in_ready", ifa.in_ready, 1);
        check("abort_busy", busy_a, 0);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_result", ifa.out_valid, 0);
        send(29'h1000000, model(29'h1000000, 12), model(29'h1000000, FWL_B));
        drain();

        // Random operands with random output backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) c = 29'($urandom_range(0, 255));
            else c = 29'($urandom);
            send(c, model(c, 12), model(c, FWL_B));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();
        rand_rdy = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
